bus_sequencer: RTL

Fixed-slot scheduler for the shared RAM/ROM bus, clocked at 16 MHz. It divides each 1 µs bus period into four 4-cycle slots: video RAM fetch, video ROM fetch, MCU (SPI bridge) access and CPU access. It generates the slot selects, address setup and strobe enables, the RAM write enable, the CPU phase-2 clock and the character clock enable consumed by the video and CPU blocks. It sits at the top level beside the video block and is the only source of the enables the video datapath uses.

---
 rtl/bus_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/bus_sequencer.sv
// Fixed-slot scheduler for the shared RAM/ROM bus: a 16-cycle period split into
// VRAM, VROM, MCU and CPU slots, with every enable registered from the next cycle count.
module bus_sequencer (
    input  logic clk16_i,
    input  logic reset_i,
    input  logic cpu_rw_ni,
    input  logic mcu_req_i,
    input  logic mcu_wr_i,
    output logic mcu_grant_o,
    output logic mcu_done_o,
    output logic vram_en_o,
    output logic vrom_en_o,
    output logic cpu_en_o,
    output logic cpu_clk_o,
    output logic cclk_en_o,
    output logic setup_en_o,
    output logic strobe_en_o,
    output logic ram_we_o
);

    localparam int unsigned CYC_W = 4;
    localparam int unsigned SLOT_W = 2;

    localparam logic [CYC_W-1:0] CYC_LAST      = CYC_W'(15);
    localparam logic [CYC_W-1:0] CYC_MCU_GRANT = CYC_W'(8);
    localparam logic [CYC_W-1:0] CYC_MCU_WE    = CYC_W'(10);
    localparam logic [CYC_W-1:0] CYC_MCU_DONE  = CYC_W'(11);
    localparam logic [CYC_W-1:0] CYC_CPU_WE    = CYC_W'(14);

    localparam logic [SLOT_W-1:0] SLOT_VRAM = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] SLOT_VROM = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_MCU  = SLOT_W'(2);

    localparam logic [1:0] OFS_SETUP  = 2'd0;
    localparam logic [1:0] OFS_STROBE = 2'd2;

    logic [CYC_W-1:0]  cycle_q;
    logic [CYC_W-1:0]  cycle_d;
    logic [SLOT_W-1:0] slot_d;
    logic [1:0]        ofs_d;
    logic              mcu_wr_q;
    logic              mcu_wr_d;
    logic              grant_d;
    logic              slot_live_d;
    logic              ram_we_d;

    // Next-cycle decode; all registered outputs are derived from cycle_d.
    always_comb begin
        cycle_d     = cycle_q + CYC_W'(1);
        slot_d      = cycle_d[CYC_W-1:2];
        ofs_d       = cycle_d[1:0];
        grant_d     = 1'b0;
        mcu_wr_d    = mcu_wr_q;
        ram_we_d    = 1'b0;

        if (cycle_d == CYC_MCU_GRANT) begin
            grant_d  = mcu_req_i;
            mcu_wr_d = mcu_wr_i;
        end else if (slot_d == SLOT_MCU) begin
            grant_d = mcu_grant_o;
        end

        // An ungranted MCU slot is idle: no setup, strobe or write.
        slot_live_d = (slot_d != SLOT_MCU) || grant_d;

        if (cycle_d == CYC_CPU_WE) begin
            ram_we_d = ~cpu_rw_ni;
        end else if (cycle_d == CYC_MCU_WE) begin
            ram_we_d = grant_d & mcu_wr_d;
        end
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            cycle_q     <= CYC_LAST;
            mcu_wr_q    <= 1'b0;
            mcu_grant_o <= 1'b0;
            mcu_done_o  <= 1'b0;
            vram_en_o   <= 1'b0;
            vrom_en_o   <= 1'b0;
            cpu_en_o    <= 1'b0;
            cpu_clk_o   <= 1'b0;
            cclk_en_o   <= 1'b0;
            setup_en_o  <= 1'b0;
            strobe_en_o <= 1'b0;
            ram_we_o    <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            mcu_wr_q    <= mcu_wr_d;
            mcu_grant_o <= grant_d;
            mcu_done_o  <= grant_d && (cycle_d == CYC_MCU_DONE);
            vram_en_o   <= (slot_d == SLOT_VRAM);
            vrom_en_o   <= (slot_d == SLOT_VROM);
            cpu_en_o    <= (cycle_d == CYC_LAST);
            cpu_clk_o   <= cycle_d[CYC_W-1];
            cclk_en_o   <= (cycle_d == CYC_LAST);
            setup_en_o  <= slot_live_d && (ofs_d == OFS_SETUP);
            strobe_en_o <= slot_live_d && (ofs_d == OFS_STROBE);
            ram_we_o    <= ram_we_d;
        end
    end

endmodule
